// File: rtl/bus_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bus_transfer_sequencer
// Description : Bus initiator. Queues (src, dst) register-transfer requests and
//               runs them one at a time. Each transfer drives a one-hot source
//               select, then a one-hot destination load. The bus value is
//               captured in the load cycle and a done pulse follows.
//               Optional macro BUS_SEQ_RANGE_CHECK_EN: out-of-range requests
//               are discarded with an err pulse instead of running with an
//               all-zero select/load.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_transfer_sequencer #(
    parameter int NUM_SRC    = 24,
    parameter int NUM_DST    = 24,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE     = 1
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [4:0]         req_src,
    input  logic [4:0]         req_dst,
    output logic [NUM_SRC-1:0] sel_out,
    output logic [NUM_DST-1:0] load_out,
    input  logic [DATA_W-1:0]  bus_in,
    output logic               done_valid,
    output logic [DATA_W-1:0]  done_data,
    output logic               busy,
    output logic               err
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_set_w = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [9:0]           r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_ready;
    logic [c_set_w-1:0]   r_settle;
    logic [4:0]           r_dst;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_start;
    logic [4:0]           w_head_src;
    logic [4:0]           w_head_dst;
    logic [c_cnt_w-1:0]   w_count_nxt;

    // Ready is registered: a slot freed by a pop only becomes visible next cycle.
    assign w_push      = req_valid & r_ready;
    // The FSM pops only when it is idle and the queue already held an entry.
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_head_src  = r_mem[r_rd_ptr][9:5];
    assign w_head_dst  = r_mem[r_rd_ptr][4:0];
    assign w_count_nxt = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

`ifdef BUS_SEQ_RANGE_CHECK_EN
    logic w_bad;
    logic r_err;

    assign w_bad   = (32'(w_head_src) >= NUM_SRC) || (32'(w_head_dst) >= NUM_DST);
    assign w_start = w_pop & ~w_bad;
    assign err     = r_err;

    // One-cycle error pulse for each discarded out-of-range entry.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_pop & w_bad;
        end
    end
`else
    // Out-of-range indices shift past the top bit, giving an all-zero select/load.
    assign w_start = w_pop;
    assign err     = 1'b0;
`endif

    assign req_ready = r_ready;
    assign busy      = (r_state != S_IDLE) || (r_count != '0);

    // Queue storage: the payload needs no reset, only the pointers and count do.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_src, req_dst};
        end
    end

    // Queue pointers, occupancy and the registered not-full flag.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != c_cnt_w'(FIFO_DEPTH));
        end
    end

    // Transfer FSM with registered select, load, done and capture outputs.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state    <= S_IDLE;
            r_settle   <= '0;
            r_dst      <= '0;
            sel_out    <= '0;
            load_out   <= '0;
            done_valid <= 1'b0;
            done_data  <= '0;
        end else begin
            done_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        sel_out  <= NUM_SRC'(1) << w_head_src;
                        r_dst    <= w_head_dst;
                        r_settle <= c_set_w'(SETTLE - 1);
                        r_state  <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (r_settle == '0) begin
                        load_out <= NUM_DST'(1) << r_dst;
                        r_state  <= S_LOAD;
                    end else begin
                        r_settle <= r_settle - c_set_w'(1);
                    end
                end
                S_LOAD: begin
                    done_data  <= bus_in;
                    sel_out    <= '0;
                    load_out   <= '0;
                    done_valid <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_transfer_sequencer
// Description : Self-checking bench for bus_transfer_sequencer. A transaction
//               model (request queue plus per-transfer timeline) predicts every
//               output each cycle; directed literal checks pin the model.
//               Honours BUS_SEQ_RANGE_CHECK_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_transfer_sequencer;

    localparam int NUM_SRC    = 24;
    localparam int NUM_DST    = 24;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int SETTLE     = 1;
`ifdef BUS_SEQ_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic              clock     = 1'b0;
    logic              clear     = 1'b0;
    logic              req_valid = 1'b0;
    logic [4:0]        req_src   = '0;
    logic [4:0]        req_dst   = '0;
    logic [DATA_W-1:0] bus_in    = '0;
    logic              req_ready;
    logic [NUM_SRC-1:0] sel_out;
    logic [NUM_DST-1:0] load_out;
    logic              done_valid;
    logic [DATA_W-1:0] done_data;
    logic              busy;
    logic              err;

    bus_transfer_sequencer #(
        .NUM_SRC(NUM_SRC), .NUM_DST(NUM_DST), .DATA_W(DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH), .SETTLE(SETTLE)
    ) dut (
        .clock(clock), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .sel_out(sel_out), .load_out(load_out),
        .bus_in(bus_in), .done_valid(done_valid), .done_data(done_data),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] onehot(input int idx);
        logic [23:0] v;
        v = '0;
        if (idx >= 0 && idx < 24) v[idx] = 1'b1;
        return v;
    endfunction

    // ---------------- transaction model ----------------
    typedef struct { int src; int dst; } req_t;
    req_t        q[$];
    req_t        m_head;
    int          n, t0, cur_src, cur_dst, err_at, d;
    bit          act, m_ready, m_idle;
    logic [31:0] m_done;
    logic [23:0] exp_sel, exp_load;
    bit          exp_done, exp_busy, exp_err;

    // Each transfer popped at edge t0 shows select after edges t0..t0+SETTLE,
    // load after t0+SETTLE, done after t0+SETTLE+1, and frees the FSM for a
    // new pop at edge t0+SETTLE+3.
    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            q.delete();
            n = 0; t0 = 0; act = 0; err_at = -1; m_ready = 0; m_done = '0;
            cur_src = 0; cur_dst = 0;
        end else begin
            n++;
            m_idle = !act || ((n - t0) >= SETTLE + 3);
            if (m_idle && q.size() > 0) begin
                m_head = q.pop_front();
                if (RANGE_CHK && (m_head.src >= NUM_SRC || m_head.dst >= NUM_DST)) begin
                    err_at = n;
                    act    = 0;
                end else begin
                    act = 1; t0 = n; cur_src = m_head.src; cur_dst = m_head.dst;
                end
            end
            if (req_valid && m_ready) q.push_back('{src: int'(req_src), dst: int'(req_dst)});
            m_ready = (q.size() != FIFO_DEPTH);
            if (act && (n - t0) == SETTLE + 1) m_done = bus_in;
        end
        d        = n - t0;
        exp_sel  = (act && d <= SETTLE) ? onehot(cur_src) : 24'h0;
        exp_load = (act && d == SETTLE) ? onehot(cur_dst) : 24'h0;
        exp_done = act && (d == SETTLE + 1);
        exp_busy = (act && d <= SETTLE + 1) || (q.size() != 0);
        exp_err  = (err_at == n) && clear;
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en   = 0;
    bit seen23   = 0;
    int cnt_done = 0;
    int cnt_err  = 0;
    int cnt_seln = 0;

    always begin
        @(negedge clock);
        #1;
        if (chk_en) begin
            check("sel_out",    sel_out,    exp_sel);
            check("load_out",   load_out,   exp_load);
            check("done_valid", done_valid, exp_done);
            check("done_data",  done_data,  m_done);
            check("busy",       busy,       exp_busy);
            check("err",        err,        exp_err);
            check("req_ready",  req_ready,  m_ready);
            if (sel_out == 24'h800000) seen23 = 1;
            if (done_valid) cnt_done++;
            if (err) cnt_err++;
            if (sel_out != '0) cnt_seln++;
        end
    end

    int base_done, base_err, base_sel;
    int srcs[6] = '{0, 6, 23, 1, 9, 4};
    int dsts[6] = '{1, 2, 3, 4, 5, 7};

    initial begin
        // Reset with random inputs: every output held at zero.
        repeat (4) begin
            @(negedge clock);
            req_valid = 1'($urandom); req_src = 5'($urandom); req_dst = 5'($urandom);
            bus_in = $urandom;
        end
        #1;
        check("rst_sel", sel_out, 0);       check("rst_load", load_out, 0);
        check("rst_done", done_valid, 0);   check("rst_data", done_data, 0);
        check("rst_busy", busy, 0);         check("rst_err", err, 0);
        check("rst_ready", req_ready, 0);
        chk_en = 1;
        @(negedge clock); req_valid = 0; clear = 1;
        repeat (2) @(negedge clock);
        #1;
        check("rel_ready", req_ready, 1);   check("rel_busy", busy, 0);

        // Single transfer src=0 dst=6 with bus_in=732.
        @(negedge clock); bus_in = 732; req_valid = 1; req_src = 0; req_dst = 6;
        @(negedge clock); req_valid = 0;
        @(negedge clock); #1;
        check("t2_sel_e1", sel_out, 24'h000001);  check("t2_load_e1", load_out, 0);
        repeat (SETTLE) @(negedge clock);
        #1;
        check("t2_load", load_out, 24'h000040);   check("t2_sel_load", sel_out, 24'h000001);
        @(negedge clock); #1;
        check("t2_done_valid", done_valid, 1);    check("t2_done_data", done_data, 732);
        @(negedge clock); #1;
        check("t2_gap_sel", sel_out, 0);          check("t2_gap_done", done_valid, 0);
        repeat (3) @(negedge clock);

        // Back-to-back burst that fills the queue; the last attempt is refused.
        base_done = cnt_done;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i == 5) check("t3_full_ready", req_ready, 0);
            bus_in = $urandom; req_valid = 1; req_src = 5'(srcs[i]); req_dst = 5'(dsts[i]);
        end
        @(negedge clock); req_valid = 0;
        repeat (40) @(negedge clock);
        check("t3_done_count", cnt_done - base_done, 5);
        check("t3_sel_src23", seen23, 1);

        // Out-of-range source index.
        base_done = cnt_done; base_err = cnt_err; base_sel = cnt_seln;
        @(negedge clock); req_valid = 1; req_src = 30; req_dst = 2;
        @(negedge clock); req_valid = 0;
        repeat (12) @(negedge clock);
        check("t4_done_count", cnt_done - base_done, RANGE_CHK ? 0 : 1);
        check("t4_err_count",  cnt_err - base_err,   RANGE_CHK ? 1 : 0);
        check("t4_sel_zero",   cnt_seln - base_sel,  0);

        // Reset asserted during the load cycle.
        @(negedge clock); req_valid = 1; req_src = 2; req_dst = 3;
        @(negedge clock); req_valid = 0;
        for (int k = 0; k < 20 && load_out == '0; k++) @(negedge clock);
        check("t5_load_reached", load_out, 24'h000008);
        clear = 0;
        #1;
        check("t5_load_drop", load_out, 0);  check("t5_sel_drop", sel_out, 0);
        check("t5_busy", busy, 0);
        base_done = cnt_done;
        @(negedge clock); clear = 1;
        repeat (6) @(negedge clock);
        check("t5_no_done", cnt_done - base_done, 0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            req_valid = ($urandom_range(0, 99) < 60);
            req_src   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            req_dst   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            bus_in    = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                clear = 0;
                @(negedge clock);
                clear = 1;
            end
        end
        @(negedge clock); req_valid = 0;
        repeat (40) @(negedge clock);
        #1;
        check("end_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
